// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state encoding and constants
package fetch_unit_pkg;
  localparam int INST_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch front end with redirect squash
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic [31:0]       inst_pc_plus_4,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [15:0]       squash_count
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_pc_q, buf_pc_d, buf_pc4_q, buf_pc4_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic drop_q, drop_d, squash;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic [31:0] tgt, pc_inc;
  logic hs;
  assign tgt = redirect_pc & ~32'h3;
  assign pc_inc = pc_q + PC_INC;
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr = pc_q;
  assign hs = imem_req_valid & imem_req_ready;
  assign inst_valid = (state_q == HOLD) & ~redirect_valid;
  assign inst_data = buf_q;
  assign inst_pc = buf_pc_q;
  assign inst_pc_plus_4 = buf_pc4_q;
  assign fetch_count = fcnt_q;
  assign squash_count = scnt_q;
  // next-state: request, wait for the word, hold it for decode; redirects squash wrong-path work
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drop_d = drop_q;
    buf_d = buf_q;
    buf_pc_d = buf_pc_q;
    buf_pc4_d = buf_pc4_q;
    fcnt_d = fcnt_q;
    squash = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        pc_d = redirect_valid ? tgt : pc_q;
        drop_d = drop_q | (hs & redirect_valid);
        state_d = hs ? WAIT : REQ;
      end
      WAIT: begin
        if (imem_rsp_valid && (drop_q || redirect_valid)) begin
          squash = 1'b1;
          drop_d = 1'b0;
          pc_d = redirect_valid ? tgt : pc_q;
          state_d = REQ;
        end else if (imem_rsp_valid) begin
          buf_d = imem_rsp_data;
          buf_pc_d = pc_q;
          buf_pc4_d = pc_inc;
          pc_d = pc_inc;
          state_d = HOLD;
        end else if (redirect_valid) begin
          pc_d = tgt;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d = tgt;
          squash = 1'b1;
          state_d = REQ;
        end else if (inst_ready) begin
          fcnt_d = fcnt_q + CNT_W'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    scnt_d = scnt_q + {15'd0, squash & ~&scnt_q};
  end
  // state, PC, buffer and counters; reset abandons any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      buf_q <= '0;
      buf_pc_q <= '0;
      buf_pc4_q <= '0;
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      buf_q <= buf_d;
      buf_pc_q <= buf_pc_d;
      buf_pc4_q <= buf_pc4_d;
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end
endmodule
